bictr_seq_ctrl: RTL and testbench
=================================

// Module: bictr_seq_ctrl
// PURPOSE
//   Sequencer for one DW03_bictr_decode up/down counter with decoded outputs.
//   Accepts step commands (start value, direction, step count) on a valid/ready handshake.
//   Drives the counter's data, up_dn, load and cen pins, then reports completion with a status code.
//   Sits between the slot/schedule logic and the counter; it is the only agent driving the counter pins.
// PARAMETERS
//   width  8  counter width in bits; the decoded counter output is (1<<width) bits; legal range 2..16
// PORTS
//   clk          in   1      rising-edge clock shared with the counter
//   reset        in   1      asynchronous, active-high reset
//   cmd_valid    in   1      command present
//   cmd_ready    out  1      command accepted when cmd_valid & cmd_ready
//   cmd_start    in   width  value loaded into the counter
//   cmd_len      in   width  number of count steps; 0 = load only
//   cmd_dir      in   1      1 = count up, 0 = count down
//   hold         in   1      stall stepping; the step count freezes
//   abort        in   1      end the active command early
//   ctr_data     out  width  to counter data
//   ctr_up_dn    out  1      to counter up_dn
//   ctr_load_n   out  1      to counter load (active-low)
//   ctr_cen      out  1      to counter cen
//   ctr_tercnt   in   1      from counter tercnt
//   busy         out  1      command in progress (LOAD or RUN)
//   steps_left   out  width  remaining steps of the current command
//   done         out  1      one-cycle completion pulse
//   done_status  out  2      valid with done: 00 complete, 01 aborted, 10 terminal stop
// BEHAVIOUR
//   - FSM states: IDLE, LOAD, RUN, DONE.
//   - Reset forces IDLE immediately; the counter is not reloaded. Reset values:
//     cmd_ready=1, busy=0, done=0, done_status=00, ctr_load_n=1, ctr_cen=0,
//     ctr_data=0, ctr_up_dn=1, steps_left=0.
//   - IDLE: cmd_ready=1. On a handshake, latch start/len/dir; ctr_data and ctr_up_dn
//     hold the latched values until the next accept. Next state is LOAD.
//   - LOAD (exactly 1 cycle): ctr_load_n=0, ctr_cen=0, steps_left<=len.
//     hold is ignored in LOAD.
//     abort in LOAD -> DONE with status 01; the load still occurs.
//     Otherwise len==0 -> DONE with status 00, else -> RUN.
//   - RUN: ctr_cen = ~hold & ~abort (combinational).
//     On each cen cycle, steps_left decrements; at steps_left==1 with cen -> DONE with status 00.
//   - abort in RUN: ctr_cen=0 that cycle; steps_left frozen; -> DONE with status 01.
//     abort has priority over hold.
//   - DONE (1 cycle): done=1; done_status valid; busy=0; cmd_ready=0; -> IDLE.
//   - Command latency is len+2 cycles from accept to done with no hold (load-only: 2 cycles).
//   - cmd_ready=0 in LOAD, RUN and DONE; cmd_valid is ignored there. No command queueing.
//   - Counter arithmetic is modulo 2^width. Without the macro, a wrap past the terminal value is legal.
//   - cmd_ready, busy, done and ctr_load_n are decoded from the registered state.
//     ctr_cen is combinational from state, hold, abort and ctr_tercnt.
// CONFIGURATION
//   - BICTR_SEQ_TERCNT_STOP_EN defined: in RUN, ctr_tercnt=1 suppresses ctr_cen.
//     The FSM goes to DONE with status 10; steps_left is frozen at its remaining value.
//     Precedence: abort > tercnt > hold.
//   - BICTR_SEQ_TERCNT_STOP_EN undefined: ctr_tercnt is ignored; status 10 is never produced.
// TESTING (width=8)
//   1. start=0x10, len=3, dir=1, no hold
//      -> one load_n=0 cycle with data=0x10, then 3 cen cycles; counter=0x13;
//         done with status 00 at cycle 5 after accept.
//   2. start=0x42, len=0 -> load only, zero cen cycles; done with status 00 2 cycles after accept.
//   3. len=4, hold high for 2 cycles after the first step
//      -> 4 cen cycles over 6 RUN cycles; steps_left holds 3 during the hold; status 00.
//   4. len=5, abort after 2 steps -> cen=0 in the abort cycle; done with status 01; steps_left=3.
//   5. start=0xFD, dir=1, len=10
//      -> with the macro: 2 steps to 0xFF, tercnt stops it, status 10, steps_left=8;
//         without the macro: counter ends at 0x07, status 00.
//   6. cmd_valid held high while busy -> no second accept until after done.
//      Reset asserted mid-RUN -> ctr_cen=0 and IDLE in the same cycle; cmd_ready=1 after release.

Source files
------------

// File: rtl/bictr_seq_ctrl.sv
// bictr_seq_ctrl
//   Sequencer for a single DW03_bictr_decode up/down counter. Accepts one
//   step command at a time (start value, direction, step count) over a
//   valid/ready handshake, loads the counter, steps it with cen, then
//   reports completion for one cycle with a status code.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_start/len/dir   load value, number of steps (0 = load only), 1 = up
//   hold                stall stepping (ignored during the load cycle)
//   abort               end the active command early
//   ctr_data/up_dn      counter data and direction, held from the last accept
//   ctr_load_n          counter synchronous load, active low
//   ctr_cen             counter count enable
//   ctr_tercnt          counter terminal-count flag
//   busy                load or stepping in progress
//   steps_left          remaining steps of the current command
//   done, done_status   completion pulse; 00 complete, 01 aborted, 10 terminal stop
//
// Build option
//   BICTR_SEQ_TERCNT_STOP_EN : when defined, ctr_tercnt ends stepping with
//   status 10 (priority abort > tercnt > hold); otherwise ctr_tercnt is
//   ignored and the counter may wrap.
module bictr_seq_ctrl #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [width-1:0] cmd_start,
  input  logic [width-1:0] cmd_len,
  input  logic             cmd_dir,
  input  logic             hold,
  input  logic             abort,
  output logic [width-1:0] ctr_data,
  output logic             ctr_up_dn,
  output logic             ctr_load_n,
  output logic             ctr_cen,
  input  logic             ctr_tercnt,
  output logic             busy,
  output logic [width-1:0] steps_left,
  output logic             done,
  output logic [1:0]       done_status
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_COMPLETE = 2'b00;
  localparam logic [1:0] ST_ABORTED  = 2'b01;
  localparam logic [1:0] ST_TERMINAL = 2'b10;

  state_t           r_state;
  state_t           w_next;
  logic [width-1:0] r_data;
  logic [width-1:0] r_len;
  logic [width-1:0] r_steps;
  logic             r_dir;
  logic [1:0]       r_status;
  logic [1:0]       w_status;
  logic             w_cen;
  logic             w_tercnt_stop;

`ifdef BICTR_SEQ_TERCNT_STOP_EN
  assign w_tercnt_stop = ctr_tercnt;
`else
  logic w_unused_tercnt;
  assign w_unused_tercnt = ctr_tercnt;
  assign w_tercnt_stop   = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_status = r_status;
    w_cen    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        // The load itself always happens; abort only skips the stepping.
        if (abort) begin
          w_next   = S_DONE;
          w_status = ST_ABORTED;
        end else if (r_len == '0) begin
          w_next   = S_DONE;
          w_status = ST_COMPLETE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next   = S_DONE;
          w_status = ST_ABORTED;
        end else if (w_tercnt_stop) begin
          w_next   = S_DONE;
          w_status = ST_TERMINAL;
        end else if (!hold) begin
          w_cen = 1'b1;
          if (r_steps == width'(1)) begin
            w_next   = S_DONE;
            w_status = ST_COMPLETE;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_len    <= '0;
      r_dir    <= 1'b1;
      r_steps  <= '0;
      r_status <= ST_COMPLETE;
    end else begin
      r_state  <= w_next;
      r_status <= w_status;
      if (r_state == S_IDLE && cmd_valid) begin
        r_data <= cmd_start;
        r_len  <= cmd_len;
        r_dir  <= cmd_dir;
      end
      if (r_state == S_LOAD) begin
        r_steps <= r_len;
      end else if (w_cen) begin
        r_steps <= r_steps - width'(1);
      end
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign ctr_load_n  = (r_state != S_LOAD);
  assign ctr_cen     = w_cen;
  assign ctr_data    = r_data;
  assign ctr_up_dn   = r_dir;
  assign steps_left  = r_steps;
  assign done_status = r_status;

endmodule

// File: tb/tb_bictr_seq_ctrl.sv
module tb_bictr_seq_ctrl;
  localparam int W = 8;
  localparam logic [W-1:0] MAXV = '1;
`ifdef BICTR_SEQ_TERCNT_STOP_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_len = '0;
  logic         cmd_dir = 1'b0;
  logic         hold = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] ctr_data;
  logic         ctr_up_dn;
  logic         ctr_load_n;
  logic         ctr_cen;
  logic         ctr_tercnt;
  logic         busy;
  logic [W-1:0] steps_left;
  logic         done;
  logic [1:0]   done_status;

  always #5 clk = ~clk;

  bictr_seq_ctrl #(.width(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_dir(cmd_dir),
    .hold(hold), .abort(abort), .ctr_data(ctr_data), .ctr_up_dn(ctr_up_dn),
    .ctr_load_n(ctr_load_n), .ctr_cen(ctr_cen), .ctr_tercnt(ctr_tercnt),
    .busy(busy), .steps_left(steps_left), .done(done), .done_status(done_status)
  );

  // Stand-in for the DW03_bictr_decode counter (not affected by reset).
  logic [W-1:0] cnt = '0;
  always @(posedge clk) begin
    if (!ctr_load_n)  cnt <= ctr_data;
    else if (ctr_cen) cnt <= ctr_up_dn ? cnt + W'(1) : cnt - W'(1);
  end
  assign ctr_tercnt = ctr_up_dn ? (cnt == MAXV) : (cnt == '0);

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a command is accepted while idle, spends one cycle
  // loading, steps while steps remain, then reports for one cycle.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_STEP = 2, PH_REPORT = 3;
  int           ph = PH_IDLE;
  logic [W-1:0] m_start = '0, m_len = '0, m_left = '0, m_data = '0;
  logic         m_dir = 1'b1;
  logic [1:0]   m_status = 2'b00;
  int           m_cens = 0;

  task automatic finish_cmd(input logic [1:0] s);
    m_status = s;
    ph = PH_REPORT;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_status", done_status, 0);
      chk("rst_load_n", ctr_load_n, 1);
      chk("rst_cen", ctr_cen, 0);
      chk("rst_data", ctr_data, 0);
      chk("rst_up_dn", ctr_up_dn, 1);
      chk("rst_steps_left", steps_left, 0);
      ph = PH_IDLE;
      m_data = '0;
      m_dir = 1'b1;
      m_left = '0;
    end else begin
      logic stepping;
      stepping = (ph == PH_STEP) && !abort && !(STOP_EN && ctr_tercnt) && !hold;
      chk("cmd_ready", cmd_ready, ph == PH_IDLE);
      chk("busy", busy, ph == PH_LOAD || ph == PH_STEP);
      chk("done", done, ph == PH_REPORT);
      chk("load_n", ctr_load_n, ph != PH_LOAD);
      chk("cen", ctr_cen, stepping);
      chk("data", ctr_data, m_data);
      chk("up_dn", ctr_up_dn, m_dir);
      chk("steps_left", steps_left, m_left);
      if (ph == PH_REPORT) begin
        logic [W-1:0] want;
        want = m_dir ? W'(int'(m_start) + m_cens) : W'(int'(m_start) - m_cens);
        chk("done_status", done_status, m_status);
        chk("ctr_final", cnt, want);
      end
      case (ph)
        PH_IDLE: if (cmd_valid) begin
          m_start = cmd_start; m_len = cmd_len; m_dir = cmd_dir; m_data = cmd_start;
          m_cens = 0;
          ph = PH_LOAD;
        end
        PH_LOAD: begin
          m_left = m_len;
          if (abort)            finish_cmd(2'b01);
          else if (m_len == '0) finish_cmd(2'b00);
          else                  ph = PH_STEP;
        end
        PH_STEP: begin
          if (abort)                       finish_cmd(2'b01);
          else if (STOP_EN && ctr_tercnt)  finish_cmd(2'b10);
          else if (!hold) begin
            m_left = m_left - W'(1);
            m_cens++;
            if (m_left == '0) finish_cmd(2'b00);
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  // Issues one command from an aligned (posedge+1) idle point; run cycle r
  // is cycle r+1 after accept, r=0 being the load cycle.
  task automatic do_cmd(input logic [W-1:0] s, input logic [W-1:0] l, input logic d,
                        input int hold_from, input int hold_cnt, input int abort_at,
                        output int lat, output logic [1:0] st, output logic [W-1:0] left,
                        output int cens, output int hold_left, output logic [W-1:0] fin,
                        output logic [W-1:0] load_data, output logic load_n1);
    bit got;
    lat = -1; st = 2'b11; left = '1; cens = 0; hold_left = -1; fin = '0;
    load_data = '0; load_n1 = 1'b1;
    cmd_start = s; cmd_len = l; cmd_dir = d; cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k < 400; k++) begin
      int r;
      r = k - 1;
      hold  = (r >= hold_from) && (r < hold_from + hold_cnt);
      abort = (r == abort_at);
      @(negedge clk);
      if (k == 1) begin load_data = ctr_data; load_n1 = ctr_load_n; end
      if (ctr_cen) cens++;
      if (hold) hold_left = int'(steps_left);
      if (done) begin
        lat = k; st = done_status; left = steps_left; fin = cnt; got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    hold = 1'b0; abort = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, cens, hl, acc;
    logic [1:0] st;
    logic [W-1:0] left, fin, ld;
    logic ln;

    #7;
    chk("pin_rst_ready", cmd_ready, 1);
    chk("pin_rst_load_n", ctr_load_n, 1);
    chk("pin_rst_up_dn", ctr_up_dn, 1);
    @(posedge clk); #1 reset = 1'b0;

    // 1: plain count up
    do_cmd(8'h10, 8'd3, 1'b1, -1, 0, -1, lat, st, left, cens, hl, fin, ld, ln);
    chk("t1_latency", lat, 5);
    chk("t1_status", st, 0);
    chk("t1_cens", cens, 3);
    chk("t1_counter", fin, 8'h13);
    chk("t1_load_data", ld, 8'h10);
    chk("t1_load_n", ln, 0);

    // 2: load only
    do_cmd(8'h42, 8'd0, 1'b1, -1, 0, -1, lat, st, left, cens, hl, fin, ld, ln);
    chk("t2_latency", lat, 2);
    chk("t2_status", st, 0);
    chk("t2_cens", cens, 0);
    chk("t2_counter", fin, 8'h42);

    // 3: hold for two cycles after the first step
    do_cmd(8'h20, 8'd4, 1'b1, 2, 2, -1, lat, st, left, cens, hl, fin, ld, ln);
    chk("t3_latency", lat, 8);
    chk("t3_status", st, 0);
    chk("t3_cens", cens, 4);
    chk("t3_steps_in_hold", hl, 3);
    chk("t3_counter", fin, 8'h24);

    // 4: abort after two down steps
    do_cmd(8'h50, 8'd5, 1'b0, -1, 0, 3, lat, st, left, cens, hl, fin, ld, ln);
    chk("t4_latency", lat, 5);
    chk("t4_status", st, 1);
    chk("t4_steps_left", left, 3);
    chk("t4_cens", cens, 2);
    chk("t4_counter", fin, 8'h4E);

    // 4b: abort during the load cycle
    do_cmd(8'h33, 8'd6, 1'b1, -1, 0, 0, lat, st, left, cens, hl, fin, ld, ln);
    chk("t4b_latency", lat, 2);
    chk("t4b_status", st, 1);
    chk("t4b_counter", fin, 8'h33);

    // 5: run into the terminal value
    do_cmd(8'hFD, 8'd10, 1'b1, -1, 0, -1, lat, st, left, cens, hl, fin, ld, ln);
    if (STOP_EN) begin
      chk("t5_latency", lat, 5);
      chk("t5_status", st, 2);
      chk("t5_steps_left", left, 8);
      chk("t5_counter", fin, 8'hFF);
    end else begin
      chk("t5_latency", lat, 12);
      chk("t5_status", st, 0);
      chk("t5_steps_left", left, 0);
      chk("t5_counter", fin, 8'h07);
    end

    // 6: valid held high while busy, then reset mid-run
    cmd_start = 8'h01; cmd_len = 8'd3; cmd_dir = 1'b1; cmd_valid = 1'b1;
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk); #1;
    end
    chk("t6_single_accept", acc, 1);
    @(negedge clk);
    chk("t6_ready_after_done", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_cen_before_reset", ctr_cen, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_reset_cen", ctr_cen, 0);
    chk("t6_reset_busy", busy, 0);
    chk("t6_reset_ready", cmd_ready, 1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_ready_after_release", cmd_ready, 1);
    @(posedge clk); #1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) cmd_start = W'($urandom);
      else if ($urandom_range(0, 1) == 0) cmd_start = W'($urandom_range(252, 255));
      else cmd_start = W'($urandom_range(0, 3));
      cmd_len  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 12));
      cmd_dir  = 1'($urandom_range(0, 1));
      hold     = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; hold = 1'b0; abort = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
